// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the decryption key-schedule slice.
// Holds the key geometry constants, the round-constant table, the forward
// S-box lookup and the state encoding of the key-schedule FSM.
package aes_pkg;

    localparam int AES_NK = 4;
    localparam int AES_NR = 10;
    localparam int KEY_W  = 128;

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction

    // Round constant used when deriving the first word of round key 'round'.
    function automatic logic [7:0] rcon(input logic [3:0] round);
        logic [7:0] r;
        case (round)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/inv_key_round.sv
// One backward step of the AES-128 key expansion (combinational).
// Given round key 'round' it reconstructs round key 'round-1'.
// Ports:
//   key   [127:0] in  : round key i, word 0 in [127:96]
//   round [3:0]   in  : i (1..10), selects the round constant
//   prev  [127:0] out : round key i-1, same word order
module inv_key_round
    import aes_pkg::*;
(
    input  logic [KEY_W-1:0] key,
    input  logic [3:0]       round,
    output logic [KEY_W-1:0] prev
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] p0, p1, p2, p3;
    logic [31:0] rot;
    logic [31:0] sub;

    assign w0 = key[127:96];
    assign w1 = key[95:64];
    assign w2 = key[63:32];
    assign w3 = key[31:0];

    // Words 1..3 of the older key fall out of the XOR chain directly;
    // word 0 needs the recovered word 3 pushed through RotWord/SubWord.
    assign p3 = w3 ^ w2;
    assign p2 = w2 ^ w1;
    assign p1 = w1 ^ w0;

    assign rot = {p3[23:0], p3[31:24]};
    assign sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};

    assign p0 = w0 ^ sub ^ {rcon(round), 24'h000000};

    assign prev = {p0, p1, p2, p3};

endmodule

// File: rtl/inv_key_schedule.sv
// Iterative AES-128 decryption key-schedule generator.
// Takes the final round key and streams round keys 10 down to 0, one per
// accepted transfer, over a valid/ready interface.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   start            : request, only honoured while idle
//   key_in [127:0]   : round-10 key, captured when start is accepted
//   busy             : high from start acceptance to the final transfer
//   key_valid        : key_out/round_idx valid
//   key_ready        : consumer accepts the current key
//   key_out [127:0]  : current round key
//   round_idx [3:0]  : round number of key_out
//   done             : one-cycle pulse after the round-0 key transfers
module inv_key_schedule
    import aes_pkg::*;
#(
    parameter int Nk = AES_NK,
    parameter int Nr = AES_NR
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    output logic             busy,
    output logic             key_valid,
    input  logic             key_ready,
    output logic [KEY_W-1:0] key_out,
    output logic [3:0]       round_idx,
    output logic             done
);

    generate
        if (Nk != 4 || Nr != 10) begin : g_bad_param
            $error("inv_key_schedule supports only Nk=4, Nr=10");
        end
    endgenerate

    state_t           state, state_next;
    logic [KEY_W-1:0] key_next;
    logic [KEY_W-1:0] prev_key;
    logic [3:0]       idx_next;
    logic             valid_next;
    logic             busy_next;
    logic             done_next;

    inv_key_round u_round (
        .key   (key_out),
        .round (round_idx),
        .prev  (prev_key)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            key_out   <= '0;
            round_idx <= '0;
            key_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            key_out   <= key_next;
            round_idx <= idx_next;
            key_valid <= valid_next;
            busy      <= busy_next;
            done      <= done_next;
        end
    end

    // All outputs are registered, so key_ready only reaches the state
    // and data registers, never key_valid/key_out combinationally.
    always_comb begin
        state_next = state;
        key_next   = key_out;
        idx_next   = round_idx;
        valid_next = key_valid;
        busy_next  = busy;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    key_next   = key_in;
                    idx_next   = 4'(Nr);
                    valid_next = 1'b1;
                    busy_next  = 1'b1;
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (key_valid && key_ready) begin
                    if (round_idx != 4'd0) begin
                        key_next = prev_key;
                        idx_next = round_idx - 4'd1;
                    end else begin
                        valid_next = 1'b0;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
